// File: rtl/project_pkg.sv
// -----------------------------------------------------------------------------
// project_pkg
// Shared project types and constants.
//   word / word_size : data and address word of the memory subsystem
//   mem_size         : number of words in the memory block; addresses at or
//                      above this value are out of range
//   NREQ_MAX         : largest supported number of memory requesters
//   req_idx_t        : index type wide enough for any requester number
//   MAX_BURST_DEF    : default burst length used by the arbiter
// -----------------------------------------------------------------------------
package project_pkg;

  localparam int word_size = 8;
  typedef logic [word_size-1:0] word;

  localparam int mem_size = 16;

  localparam int NREQ_MAX      = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef logic [$clog2(NREQ_MAX)-1:0] req_idx_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Searches req starting at index
// 'start' and wrapping modulo NREQ; the first set bit wins.
//   req    in  NREQ       request vector
//   start  in  req_idx_t  index searched first
//   onehot out NREQ       one-hot winner (all zero when req is zero)
//   idx    out req_idx_t  index of the winner (zero when req is zero)
// -----------------------------------------------------------------------------
module rr_pick
  import project_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  req_idx_t        start,
  output logic [NREQ-1:0] onehot,
  output req_idx_t        idx
);

  logic hit;
  int   cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    hit    = 1'b0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(start) + k) % NREQ;
      // Constant bit indices keep the select width-clean for any NREQ.
      for (int j = 0; j < NREQ; j++) begin
        if (!hit && (j == cand) && req[j]) begin
          hit       = 1'b1;
          onehot[j] = 1'b1;
          idx       = req_idx_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port memory between NREQ requesters with round-robin
// arbitration and a bounded burst. Grants are combinational; read data and
// the error flag come back registered one cycle after the grant.
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req/we             per-requester request and write select
//   addr/wdata         per-requester address and write data
//   gnt                one-hot grant, access taken this cycle
//   rvalid/rdata       one-hot read valid and shared registered read data
//   err                one-cycle pulse after an out-of-range access
//   mem_addr/mem_wr_data/mem_wr_en  drive the memory port
//   mem_rd_data        combinational read data from the memory
// -----------------------------------------------------------------------------
module mem_arbiter
  import project_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ-1:0]                 we,
  input  logic [NREQ-1:0][word_size-1:0]  addr,
  input  logic [NREQ-1:0][word_size-1:0]  wdata,
  output logic [NREQ-1:0]                 gnt,
  output logic [NREQ-1:0]                 rvalid,
  output word                             rdata,
  output logic                            err,
  output word                             mem_addr,
  output word                             mem_wr_data,
  output logic                            mem_wr_en,
  input  word                             mem_rd_data
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  req_idx_t        owner_q, owner_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic            held_q, held_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  word             rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] gnt_int;
  req_idx_t        pick_idx;
  req_idx_t        win_idx;
  req_idx_t        start_idx;
  logic            keep;
  logic            any_gnt;
  word             sel_addr;
  word             sel_wdata;
  logic            sel_we;
  logic            in_range;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_oh[i] = (req_idx_t'(i) == owner_q);
    end
    start_idx = (owner_q == req_idx_t'(NREQ - 1)) ? '0 : req_idx_t'(owner_q + req_idx_t'(1));
  end

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .start  (start_idx),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // held_q is clear only between reset and the first grant. It stops the
  // reset owner (NREQ-1) from claiming the port, so requester 0 wins first.
  always_comb begin
    keep = held_q && (|(req & owner_oh)) &&
           ((burst_cnt_q < BURST_LAST) || !(|(req & ~owner_oh)));
    gnt_int = keep ? owner_oh : pick_oh;
    win_idx = keep ? owner_q  : pick_idx;
    gnt     = rst_n ? gnt_int : '0;
    any_gnt = |gnt;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt[j]) begin
        sel_addr  = addr[j];
        sel_wdata = wdata[j];
        sel_we    = we[j];
      end
    end
    in_range    = (sel_addr < word'(mem_size));
    mem_addr    = sel_addr;
    mem_wr_data = sel_wdata;
    mem_wr_en   = any_gnt && sel_we && in_range;
  end

  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    held_d      = held_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    if (any_gnt) begin
      owner_d = win_idx;
      held_d  = 1'b1;
      if (win_idx == owner_q) begin
        burst_cnt_d = (burst_cnt_q == BURST_LAST) ? burst_cnt_q : burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_d = '0;
      end
      if (!sel_we) begin
        rvalid_d = gnt;
        rdata_d  = in_range ? mem_rd_data : '0;
      end
      err_d = !in_range;
    end
  end

  // ---- response / arbitration state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= req_idx_t'(NREQ - 1);
      burst_cnt_q <= '0;
      held_q      <= 1'b0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      held_q      <= held_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench: mem_arbiter (NREQ=2, MAX_BURST=4) in front of a 16-word
// memory model with combinational read and clocked write.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import project_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [1:0][7:0] addr;
  logic [1:0][7:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      rvalid;
  word             rdata;
  logic            err;
  word             mem_addr;
  word             mem_wr_data;
  logic            mem_wr_en;
  word             mem_rd_data;

  int errors = 0;
  int checks = 0;

  // Memory model; low address bits only, so a leaked out-of-range write
  // would alias onto word 0.
  logic [7:0] mem [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                           8'h18, 8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h1d, 8'h1e, 8'h1f};

  assign mem_rd_data = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wr_data;
  end

  mem_arbiter #(.NREQ(2), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [1:0] exp_gnt [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    we    = 2'b11;
    addr  = '0;
    wdata = '0;
    addr[0] = 8'd5;
    addr[1] = 8'd5;
    #2;
    chk("rst_gnt",    32'(gnt), 32'h0);
    chk("rst_wr_en",  32'(mem_wr_en), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata",  32'(rdata), 32'h0);
    chk("rst_err",    32'(err), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    req   = 2'b00;
    we    = 2'b00;
    tick();

    // Single writer then reader on requester 0
    req = 2'b01; we = 2'b01; addr[0] = 8'd5; wdata[0] = 8'hA5;
    mid();
    chk("wr_gnt",   32'(gnt), 32'h1);
    chk("wr_en",    32'(mem_wr_en), 32'h1);
    chk("wr_addr",  32'(mem_addr), 32'h5);
    chk("wr_data",  32'(mem_wr_data), 32'hA5);
    tick();
    we = 2'b00;
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    mid();
    chk("rd_gnt",   32'(gnt), 32'h1);
    chk("rd_wr_en", 32'(mem_wr_en), 32'h0);
    tick();
    req = 2'b00;
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata",  32'(rdata), 32'hA5);
    mid();
    chk("idle_gnt",  32'(gnt), 32'h0);
    chk("idle_addr", 32'(mem_addr), 32'h0);
    tick();

    // Reset again so the burst run starts from the reset owner
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11; we = 2'b00; addr[0] = 8'd5; addr[1] = 8'd6;
    for (int k = 0; k < 9; k++) begin
      mid();
      chk($sformatf("burst_gnt%0d", k), 32'(gnt), 32'(exp_gnt[k]));
      if (k > 0) begin
        chk($sformatf("burst_rvalid%0d", k), 32'(rvalid), 32'(exp_gnt[k-1]));
        chk($sformatf("burst_rdata%0d", k), 32'(rdata),
            (exp_gnt[k-1] == 2'b01) ? 32'hA5 : 32'h16);
      end
      tick();
    end
    req = 2'b00;
    chk("burst_last_rvalid", 32'(rvalid), 32'h1);
    chk("burst_last_rdata",  32'(rdata), 32'hA5);

    // Lone owner on requester 1 is never preempted
    req = 2'b10;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk($sformatf("lone_gnt%0d", k), 32'(gnt), 32'h2);
      tick();
    end
    chk("lone_burst_sat", 32'(dut.burst_cnt_q), 32'h3);
    chk("lone_rvalid", 32'(rvalid), 32'h2);
    chk("lone_rdata",  32'(rdata), 32'h16);
    req = 2'b11;
    mid();
    chk("lone_handover_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    chk("handover_rvalid", 32'(rvalid), 32'h1);
    chk("handover_rdata",  32'(rdata), 32'hA5);

    // Out-of-range write then read
    req = 2'b01; we = 2'b01; addr[0] = 8'd16; wdata[0] = 8'hFF;
    mid();
    chk("oor_wr_gnt",   32'(gnt), 32'h1);
    chk("oor_wr_en",    32'(mem_wr_en), 32'h0);
    chk("oor_wr_addr",  32'(mem_addr), 32'h10);
    tick();
    we = 2'b00;
    chk("oor_wr_err",    32'(err), 32'h1);
    chk("oor_wr_rvalid", 32'(rvalid), 32'h0);
    mid();
    chk("oor_rd_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    chk("oor_rd_err",    32'(err), 32'h1);
    chk("oor_rd_rvalid", 32'(rvalid), 32'h1);
    chk("oor_rd_rdata",  32'(rdata), 32'h0);
    chk("oor_mem0",      32'(mem[0]), 32'h10);
    tick();
    chk("oor_err_done",  32'(err), 32'h0);
    chk("oor_rvalid_done", 32'(rvalid), 32'h0);
    chk("oor_rdata_hold", 32'(rdata), 32'h0);

    // Reset in the grant cycle of a read while a previous read is returning
    req = 2'b01; we = 2'b00; addr[0] = 8'd5;
    mid();
    chk("mr_gnt_a", 32'(gnt), 32'h1);
    tick();
    chk("mr_rvalid_a", 32'(rvalid), 32'h1);
    chk("mr_rdata_a",  32'(rdata), 32'hA5);
    chk("mr_gnt_b",    32'(gnt), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_gnt",    32'(gnt), 32'h0);
    chk("mr_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mr_rst_rdata",  32'(rdata), 32'h0);
    tick();
    chk("mr_rst_rvalid2", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
    req = 2'b11; addr[1] = 8'd6;
    mid();
    chk("mr_prio_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    chk("mr_post_rvalid", 32'(rvalid), 32'h1);
    chk("mr_post_rdata",  32'(rdata), 32'hA5);
    chk("mr_mem5",        32'(mem[5]), 32'hA5);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port `memory` block between NREQ requesters, e.g. the fetch unit, the data path and the loader/DMA.
- Arbitration is round-robin with a bounded burst. A requester may keep the port for up to MAX_BURST back-to-back accesses while others wait.
- The arbiter drives the memory address, write-data and write-enable lines directly.
- It returns registered read data, with a one-hot valid, one cycle after grant.
- It sits between the requesters and `memory`; `memory` itself is unchanged.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive grants to one owner while another requester is pending (1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request, level.
- we  in  NREQ  per-requester write select (1 = write, 0 = read).
- addr  in  NREQ x word  per-requester address.
- wdata  in  NREQ x word  per-requester write data.
- gnt  out  NREQ  one-hot grant; the access is taken this cycle.
- rvalid  out  NREQ  one-hot; rdata is valid for this requester this cycle.
- rdata  out  word  registered read data, shared by all requesters.
- err  out  1  one-cycle pulse, one cycle after a granted out-of-range access.
- mem_addr  out  word  to memory addr.
- mem_wr_data  out  word  to memory wr_data.
- mem_wr_en  out  1  to memory wr_en.
- mem_rd_data  in  word  from memory rd_data (combinational read).

Behaviour:
- Reset (async on rst_n low):
  - owner = NREQ-1, so requester 0 wins first after reset; burst_cnt = 0.
  - rvalid = 0, rdata = 0, err = 0.
  - Combinational outputs follow from state: gnt = 0 and mem_wr_en = 0 while rst_n is low.
- Grant is combinational within the cycle. At most one gnt bit is high. gnt[i] implies req[i].
- Selection each cycle:
  - Owner keeps the grant if req[owner]=1 and either burst_cnt < MAX_BURST-1 or no other req bit is set.
  - Otherwise the winner is the first set req bit searching owner+1, owner+2, ... modulo NREQ.
- No request: gnt = 0, mem_wr_en = 0, mem_addr = 0, mem_wr_data = 0. owner and burst_cnt hold.
- On a grant to requester w:
  - mem_addr = addr[w] and mem_wr_data = wdata[w].
  - mem_wr_en = we[w] AND (addr[w] < mem_size).
- Registered updates at the clock edge ending a grant cycle:
  - If w == owner, burst_cnt increments, saturating at MAX_BURST-1. If w != owner, burst_cnt = 0.
  - owner = w.
- Write latency: data is committed at the clock edge ending the grant cycle. No response pulse is generated for writes.
- Read latency: 1 cycle.
  - At the edge ending the grant cycle, rdata <= mem_rd_data, or 0 if addr[w] >= mem_size.
  - rvalid[w] = 1 for exactly the next cycle.
  - Back-to-back reads give back-to-back rvalid.
  - rdata holds its value when rvalid = 0.
- Out-of-range (addr[w] >= mem_size): the access is still granted, the write is suppressed, the read returns 0, and err pulses the next cycle.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt.
  - Dropping req before gnt is legal and leaves no side effects.
  - Keeping req high after gnt means a new access.
- Simultaneous release: if the owner drops req in the same cycle others are pending, round-robin resumes from owner+1. burst_cnt resets to 0 on the ownership change.
- Reset mid-operation: a pending rvalid or err is cancelled immediately. A write whose edge coincides with rst_n low is not guaranteed.

Decomposition:
- Shared-package additions in project_pkg (word, word_size and mem_size are already there):
  - typedef req_idx_t = logic [$clog2(NREQ_MAX)-1:0].
  - Constant NREQ_MAX = 8.
  - Constant MAX_BURST_DEF = 4.
- Sub-module `rr_pick`:
  - Combinational rotating-priority encoder.
  - Inputs: req vector and start index. Outputs: one-hot and index.
  - Parameterised by NREQ; verified standalone.
- `mem_arbiter` contains the owner/burst state, the mux to memory and the read/err response registers.
- Bench wrapper instantiates `mem_arbiter` plus `memory`.

Test Plan:
- Single writer, then reader: after reset, req[0] write addr=5 wdata=8'hA5, then read addr=5. Expected: gnt[0] in both cycles, mem_wr_en=1 in the first only; the cycle after the read grant gives rvalid=2'b01 and rdata=8'hA5.
- Reset priority: req=2'b11 as the first request after reset. Expected: gnt=2'b01 in that cycle.
- Burst limit: MAX_BURST=4, both requesters hold req with reads. Expected gnt sequence 01,01,01,01,10,10,10,10,01,... with rvalid following each grant by 1 cycle.
- Lone owner is never preempted: only req[1] held for 10 cycles. Expected: gnt[1]=1 all 10 cycles and burst_cnt saturated at 3. req[0] then rises; expected gnt=2'b01 on the next cycle.
- Out of range: write addr=mem_size wdata=8'hFF, then read addr=mem_size. Expected: mem_wr_en=0, the read gives rdata=0, err pulses 1 cycle after each grant, and memory content is unchanged.
- Reset mid-read: assert rst_n=0 in the grant cycle of a read. Expected: rvalid=0, rdata=0, gnt=0; after release, requester 0 has priority.
